// File: rtl/mask_scan_pkg.sv
// Shared types and constants for the mask scan decoder.
package mask_scan_pkg;

    localparam int unsigned MASK_SCAN_DEFAULT_WIDTH = 32;

    // Run counter saturates here: two or more runs means "not contiguous".
    localparam logic [1:0] MASK_SCAN_RUNS_SAT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } mask_scan_state_t;

endpackage

// File: rtl/mask_run_tracker.sv
// Per-bit accumulator: population count, first/last set index, run count.
// Empty/contig flags are registered alongside the counters so that every
// result output is a flop.
module mask_run_tracker
    import mask_scan_pkg::*;
#(
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic             cur_bit,
    input  logic [IDX_W-1:0] idx,
    output logic [IDX_W:0]   count,
    output logic [IDX_W-1:0] first,
    output logic [IDX_W-1:0] last,
    output logic             empty,
    output logic             contig
);

    logic [1:0]     runs;
    logic           prev;
    logic [IDX_W:0] count_nxt;
    logic [1:0]     runs_nxt;

    // Next count/run values for the bit being consumed this cycle.
    always_comb begin
        count_nxt = count;
        runs_nxt  = runs;
        if (cur_bit) begin
            count_nxt = count + (IDX_W+1)'(1);
            if (!prev && (runs != MASK_SCAN_RUNS_SAT)) begin
                runs_nxt = runs + 2'd1;
            end
        end
    end

    // Accumulator registers; clr wins over step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            first  <= '0;
            last   <= '0;
            runs   <= '0;
            prev   <= 1'b0;
            empty  <= 1'b0;
            contig <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            first  <= '0;
            last   <= '0;
            runs   <= '0;
            prev   <= 1'b0;
            empty  <= 1'b0;
            contig <= 1'b0;
        end else if (step) begin
            count  <= count_nxt;
            runs   <= runs_nxt;
            prev   <= cur_bit;
            empty  <= (count_nxt == '0);
            contig <= (runs_nxt <= 2'd1);
            if (cur_bit) begin
                last <= idx;
                if (count == '0) begin
                    first <= idx;
                end
            end
        end
    end

endmodule

// File: rtl/mask_scan_decoder.sv
// Sequential LSB-first decoder of a WIDTH-bit mask: count, first/last set
// index, empty and single-run flags. Optional build macro
// MASK_SCAN_DECODER_ASSERT_EN compiles in structural output properties.
module mask_scan_decoder
    import mask_scan_pkg::*;
#(
    parameter int unsigned WIDTH = MASK_SCAN_DEFAULT_WIDTH,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W:0]   out_count,
    output logic [IDX_W-1:0] out_first,
    output logic [IDX_W-1:0] out_last,
    output logic             out_empty,
    output logic             out_contig
);

    mask_scan_state_t state;
    mask_scan_state_t state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] k;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (k == IDX_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = SCAN;
            SCAN:    if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Shift register and bit index; k holds at WIDTH-1 after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            k     <= '0;
        end else if (accept) begin
            shreg <= in_mask;
            k     <= '0;
        end else if (state == SCAN) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            if (!last_bit) begin
                k <= k + IDX_W'(1);
            end
        end
    end

    mask_run_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .step    (state == SCAN),
        .cur_bit (shreg[0]),
        .idx     (k),
        .count   (out_count),
        .first   (out_first),
        .last    (out_last),
        .empty   (out_empty),
        .contig  (out_contig)
    );

`ifdef MASK_SCAN_DECODER_ASSERT_EN
    logic [IDX_W:0] span;
    assign span = (IDX_W+1)'(out_last) - (IDX_W+1)'(out_first) + (IDX_W+1)'(1);

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        out_count <= (IDX_W+1)'(WIDTH));
    a_empty: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (out_empty == (out_count == '0)));
    a_order: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_empty) |-> ((out_first <= out_last) && (out_count <= span)));
    a_contig: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && out_contig && !out_empty) |-> (out_count == span));
`endif

endmodule

// File: tb/tb_mask_scan_decoder.sv
module tb_mask_scan_decoder;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 5;

    typedef struct {
        logic [WIDTH-1:0] mask;
        int               count;
        int               first;
        int               last;
        int               empty;
        int               contig;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W:0]   out_count;
    logic [IDX_W-1:0] out_first;
    logic [IDX_W-1:0] out_last;
    logic             out_empty;
    logic             out_contig;

    int checks = 0;
    int errors = 0;

    mask_scan_decoder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mask    (in_mask),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_empty  (out_empty),
        .out_contig (out_contig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Called #1 after an accept edge; counts edges until out_valid, bounded.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input vec_t v, input int cyc);
        check("latency", cyc, WIDTH);
        check("out_valid", int'(out_valid), 1);
        check("in_ready_done", int'(in_ready), 0);
        check("count", int'(out_count), v.count);
        check("first", int'(out_first), v.first);
        check("last", int'(out_last), v.last);
        check("empty", int'(out_empty), v.empty);
        check("contig", int'(out_contig), v.contig);
    endtask

    // Full transaction from IDLE: offer, accept, wait, check, release.
    task automatic do_vector(input vec_t v);
        int cyc;
        check("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        in_mask  = v.mask;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(cyc);
        check_result(v, cyc);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t vecs[6];
    vec_t v_bp;
    vec_t v_post;

    initial begin
        int cyc;
        vecs[0] = '{mask: 32'h000000ff, count: 8,  first: 0,  last: 7,  empty: 0, contig: 1};
        vecs[1] = '{mask: 32'hffffff00, count: 24, first: 8,  last: 31, empty: 0, contig: 1};
        vecs[2] = '{mask: 32'h80000001, count: 2,  first: 0,  last: 31, empty: 0, contig: 0};
        vecs[3] = '{mask: 32'hffffffff, count: 32, first: 0,  last: 31, empty: 0, contig: 1};
        vecs[4] = '{mask: 32'h00000000, count: 0,  first: 0,  last: 0,  empty: 1, contig: 1};
        vecs[5] = '{mask: 32'h00010000, count: 1,  first: 16, last: 16, empty: 0, contig: 1};
        v_bp    = '{mask: 32'h0000f0f0, count: 8,  first: 4,  last: 15, empty: 0, contig: 0};
        v_post  = '{mask: 32'h00000003, count: 2,  first: 0,  last: 1,  empty: 0, contig: 1};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_mask   = 32'hffffffff;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(out_count), 0);
        check("rst_first", int'(out_first), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_empty", int'(out_empty), 0);
        check("rst_contig", int'(out_contig), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", int'(in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            do_vector(vecs[i]);
        end

        // Backpressure: hold result in DONE while a second mask waits.
        in_valid = 1'b1;
        in_mask  = vecs[0].mask;
        @(posedge clk);
        #1;
        in_mask = v_bp.mask;
        wait_result(cyc);
        check_result(vecs[0], cyc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_count", int'(out_count), 8);
            check("bp_last", int'(out_last), 7);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_in_ready", int'(in_ready), 1);
        check("bp_idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted", int'(in_ready), 0);
        wait_result(cyc);
        check_result(v_bp, cyc);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a scan, after bit 10 is consumed.
        in_valid = 1'b1;
        in_mask  = 32'hffffff00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid_count", int'(out_count), 3);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_in_ready", int'(in_ready), 1);
        check("mrst_out_valid", int'(out_valid), 0);
        check("mrst_count", int'(out_count), 0);
        check("mrst_first", int'(out_first), 0);
        check("mrst_last", int'(out_last), 0);
        check("mrst_empty", int'(out_empty), 0);
        check("mrst_contig", int'(out_contig), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_vector(v_post);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
